// File: rtl/int_to_posit_seq.sv
// int_to_posit_seq
//   Multi-cycle converter from a signed two's-complement integer to
//   posit<N,ES>. The operand is normalised one bit per cycle, then the
//   regime/exponent/fraction body is assembled, rounded or truncated,
//   saturated to maxpos and sign-applied in a single encode cycle.
//
// Parameters
//   IN_W  input integer width (signed), >= 2
//   N     posit width, >= 4
//   ES    exponent field width, 0..N-3
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data valid
//   in_ready   converter can accept (IDLE only)
//   in_data    signed integer operand
//   out_valid  out_posit valid, held until accepted
//   out_ready  downstream accepts out_posit
//   out_posit  posit result
//   busy       high in any state other than IDLE
//
// Build option
//   INT2POSIT_RNE_EN  defined: round-to-nearest-even
//                     undefined: truncate magnitude toward zero
//
// States
//   IDLE | waiting for an operand, in_ready high
//   NORM | shifting mag left until its MSB is set
//   ENC  | assembling, rounding and signing the posit
//   OUT  | holding out_posit until out_ready
module int_to_posit_seq #(
  parameter int IN_W = 16,
  parameter int N    = 8,
  parameter int ES   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_posit,
  output logic            busy
);

  localparam int SW = $clog2(IN_W);
  localparam int RW = ES + IN_W;      // {0, e, fraction}
  localparam int LW = N - 1 + RW;     // regime ones field + RW
  localparam logic [SW-1:0] E_MASK = SW'((1 << ES) - 1);

`ifdef INT2POSIT_RNE_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, NORM, ENC, OUT} state_t;

  state_t          state;
  logic            sign;
  logic [IN_W-1:0] mag;
  logic [SW-1:0]   scale;

  logic [IN_W-1:0] abs_in;
  logic [SW-1:0]   k_val;
  logic            sat;
  logic [31:0]     sh;
  logic [RW-1:0]   rem;
  logic [LW-1:0]   lv;
  logic [N-2:0]    body;
  logic            guard;
  logic            sticky;
  logic            round_up;
  logic [N-1:0]    rounded;
  logic [N-2:0]    mag_p;
  logic [N-1:0]    enc_posit;

  always_comb begin
    abs_in = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;
  end

  // The regime is k+1 ones then a zero. Placing N-1 ones above {0,e,frac}
  // and shifting left by N-2-k leaves exactly k+1 ones followed by the
  // terminating zero (the top bit of rem, always 0 since e < 2^ES).
  always_comb begin
    k_val    = scale >> ES;
    sat      = (32'(k_val) >= 32'(N - 2));
    sh       = sat ? 32'd0 : (32'(N - 2) - 32'(k_val));
    rem      = (RW'(scale & E_MASK) << (IN_W - 1)) | RW'(mag[IN_W-2:0]);
    lv       = {{(N-1){1'b1}}, rem} << sh;
    body     = lv[LW-1 -: N-1];
    guard    = lv[LW-N];
    sticky   = |lv[LW-N-1:0];
    round_up = RNE & guard & (sticky | body[0]);
    rounded  = {1'b0, body} + N'(round_up);
    if (sat || rounded[N-1])
      mag_p = '1;
    else
      mag_p = rounded[N-2:0];
    enc_posit = sign ? (~{1'b0, mag_p} + N'(1)) : {1'b0, mag_p};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sign      <= 1'b0;
      mag       <= '0;
      scale     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_posit <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign     <= in_data[IN_W-1];
            mag      <= abs_in;
            scale    <= SW'(IN_W - 1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (abs_in == '0) begin
              out_posit <= '0;
              out_valid <= 1'b1;
              state     <= OUT;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag[IN_W-1]) begin
            state <= ENC;
          end else begin
            mag   <= mag << 1;
            scale <= scale - SW'(1);
          end
        end
        ENC: begin
          out_posit <= enc_posit;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
